// File: rtl/hif_fir_engine.sv
// hif_fir_engine: consumer end of the high-frequency sample queue.
// One signed 16x16 multiply-accumulate per queued sample against an external
// coefficient ROM; one saturated 16-bit result per well-formed burst.
//
// Optional feature macro: HIF_FIR_ROUND_EN (round-half-up before the >>15).
//
// Ports:
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   sequencing  queue strobe, high for NUM_TAPS cycles per burst
//   smpl_in     signed sample, valid the cycle after its sequencing cycle
//   coeff_addr  coefficient ROM address (ROM has a 1-cycle registered read)
//   coeff       signed Q1.15 coefficient, valid the cycle after coeff_addr
//   smpl_out    signed saturated result, held until the next result
//   valid       one-cycle pulse when smpl_out updates
//   seq_err     one-cycle pulse on a malformed burst
module hif_fir_engine #(
    parameter int unsigned NUM_TAPS = 1531,
    parameter int unsigned ADDR_W   = 11
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                sequencing,
    input  logic signed [15:0]  smpl_in,
    output logic [ADDR_W-1:0]   coeff_addr,
    input  logic signed [15:0]  coeff,
    output logic signed [15:0]  smpl_out,
    output logic                valid,
    output logic                seq_err
);

    localparam int unsigned ACC_W = 32 + $clog2(NUM_TAPS);
    localparam int unsigned SH_W  = ACC_W - 14;
    localparam logic [ADDR_W-1:0] LAST_TAP = ADDR_W'(NUM_TAPS - 1);
    localparam logic signed [SH_W-1:0] SAT_HI = SH_W'(32'sd32767);
    localparam logic signed [SH_W-1:0] SAT_LO = SH_W'(-32'sd32768);
`ifdef HIF_FIR_ROUND_EN
    localparam logic signed [ACC_W:0] RND = (ACC_W + 1)'(32'sh4000);
`else
    localparam logic signed [ACC_W:0] RND = '0;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCUM,
        S_DRAIN,
        S_OUT,
        S_FLUSH
    } state_t;

    state_t                    state, state_n;
    logic [ADDR_W-1:0]         tap_cnt, tap_cnt_n;
    logic                      done, done_n;
    logic                      drain, drain_n;
    logic                      valid_n, seq_err_n;
    logic signed [15:0]        smpl_out_n;
    logic                      take, acc_clr;

    logic                      take_q;
    logic                      prod_vld;
    logic signed [31:0]        product;
    logic signed [ACC_W-1:0]   acc;

    logic signed [ACC_W:0]     acc_rnd;
    logic signed [SH_W-1:0]    acc_sh;
    logic signed [15:0]        sat_val;

    assign coeff_addr = tap_cnt;

    // Scale the accumulator to Q1.15 and clamp to the 16-bit range.
    always_comb begin
        acc_rnd = (ACC_W + 1)'(acc) + RND;
        acc_sh  = SH_W'(acc_rnd >>> 15);
        sat_val = acc_sh[15:0];
        if (acc_sh > SAT_HI) begin
            sat_val = 16'sh7FFF;
        end else if (acc_sh < SAT_LO) begin
            sat_val = 16'sh8000;
        end
    end

    // State register and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            tap_cnt  <= '0;
            done     <= 1'b0;
            drain    <= 1'b0;
            valid    <= 1'b0;
            seq_err  <= 1'b0;
            smpl_out <= '0;
        end else begin
            state    <= state_n;
            tap_cnt  <= tap_cnt_n;
            done     <= done_n;
            drain    <= drain_n;
            valid    <= valid_n;
            seq_err  <= seq_err_n;
            smpl_out <= smpl_out_n;
        end
    end

    // Next-state and output decode.
    always_comb begin
        state_n    = state;
        tap_cnt_n  = tap_cnt;
        done_n     = done;
        drain_n    = drain;
        valid_n    = 1'b0;
        seq_err_n  = 1'b0;
        smpl_out_n = smpl_out;
        take       = 1'b0;
        acc_clr    = 1'b0;

        unique case (state)
            S_IDLE: begin
                if (sequencing) begin
                    // t0: tap 0 is addressed already, start counting.
                    state_n   = S_ACCUM;
                    take      = 1'b1;
                    acc_clr   = 1'b1;
                    tap_cnt_n = ADDR_W'(1);
                    done_n    = 1'b0;
                end
            end
            S_ACCUM: begin
                if (sequencing) begin
                    if (!done) begin
                        take = 1'b1;
                        // Stop at the last tap so coeff_addr holds it.
                        if (tap_cnt == LAST_TAP) begin
                            done_n = 1'b1;
                        end else begin
                            tap_cnt_n = tap_cnt + ADDR_W'(1);
                        end
                    end else begin
                        seq_err_n = 1'b1;
                        state_n   = S_FLUSH;
                    end
                end else if (done) begin
                    state_n = S_DRAIN;
                    drain_n = 1'b0;
                end else begin
                    seq_err_n = 1'b1;
                    state_n   = S_IDLE;
                    tap_cnt_n = '0;
                    done_n    = 1'b0;
                end
            end
            S_DRAIN: begin
                seq_err_n = sequencing;
                if (drain) begin
                    state_n    = S_OUT;
                    valid_n    = 1'b1;
                    smpl_out_n = sat_val;
                end else begin
                    drain_n = 1'b1;
                end
            end
            S_OUT: begin
                seq_err_n = sequencing;
                state_n   = S_IDLE;
                tap_cnt_n = '0;
                done_n    = 1'b0;
            end
            S_FLUSH: begin
                // Over-long burst: swallow samples until the strobe drops.
                if (!sequencing) begin
                    state_n   = S_IDLE;
                    tap_cnt_n = '0;
                    done_n    = 1'b0;
                end
            end
            default: begin
                state_n   = S_IDLE;
                tap_cnt_n = '0;
                done_n    = 1'b0;
            end
        endcase
    end

    // Two-stage MAC: product register, then accumulate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            take_q   <= 1'b0;
            prod_vld <= 1'b0;
            product  <= '0;
            acc      <= '0;
        end else begin
            take_q   <= take;
            prod_vld <= take_q;
            if (take_q) begin
                product <= 32'(smpl_in) * 32'(coeff);
            end
            // Clear wins over a trailing product from an aborted burst.
            if (acc_clr) begin
                acc <= '0;
            end else if (prod_vld) begin
                acc <= acc + ACC_W'(product);
            end
        end
    end

endmodule

// File: tb/tb_hif_fir_engine.sv
// Self-checking bench for hif_fir_engine with NUM_TAPS=8: directed vector
// table, a mid-burst reset sequence and randomized bursts against a
// plain-arithmetic dot-product model.
module tb_hif_fir_engine;

    localparam int NT = 8;
    localparam int AW = 11;
`ifdef HIF_FIR_ROUND_EN
    localparam logic [15:0] TINY_OUT = 16'h0001;
`else
    localparam logic [15:0] TINY_OUT = 16'h0000;
`endif

    logic               clk;
    logic               rst_n;
    logic               sequencing;
    logic signed [15:0] smpl_in;
    logic [AW-1:0]      coeff_addr;
    logic signed [15:0] coeff;
    logic signed [15:0] smpl_out;
    logic               valid;
    logic               seq_err;

    logic [15:0] rom  [0:NT-1];
    logic [15:0] samp [0:NT-1];

    int checks = 0;
    int errors = 0;

    hif_fir_engine #(.NUM_TAPS(NT), .ADDR_W(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sequencing (sequencing),
        .smpl_in    (smpl_in),
        .coeff_addr (coeff_addr),
        .coeff      (coeff),
        .smpl_out   (smpl_out),
        .valid      (valid),
        .seq_err    (seq_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Coefficient ROM with a one-cycle registered read.
    initial coeff = '0;
    always @(posedge clk) begin
        if (int'(coeff_addr) < NT) coeff <= rom[coeff_addr[2:0]];
        else coeff <= 16'hDEAD;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int          len;
        int          win;
        int          gl;
        logic [15:0] c0;
        logic [15:0] cr;
        logic [15:0] s0;
        logic [15:0] sr;
        logic        ev;
        logic [15:0] out;
        logic        ee;
        int          ecyc;
    } vec_t;

    vec_t tbl [0:7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic fill(input logic [15:0] c0, input logic [15:0] cr,
                        input logic [15:0] s0, input logic [15:0] sr);
        for (int k = 0; k < NT; k++) begin
            rom[k]  = (k == 0) ? c0 : cr;
            samp[k] = (k == 0) ? s0 : sr;
        end
    endtask

    // Dot product of the stored burst, scaled and clamped to 16 bits.
    function automatic logic [15:0] ref_out();
        longint acc;
        acc = 0;
        for (int k = 0; k < NT; k++)
            acc += longint'($signed(samp[k])) * longint'($signed(rom[k]));
`ifdef HIF_FIR_ROUND_EN
        acc += 16384;
`endif
        acc = acc >>> 15;
        if (acc > 32767) return 16'h7FFF;
        if (acc < -32768) return 16'h8000;
        return acc[15:0];
    endfunction

    // Drive one burst starting now (t0 is the next rising edge); j counts
    // edges after t0 and outputs are sampled on the following falling edge.
    task automatic run_burst(input int len, input int win, input int gl,
                             output int vcnt, output int vcyc,
                             output int ecnt, output int ecyc);
        vcnt = 0; vcyc = -1; ecnt = 0; ecyc = -1;
        sequencing = 1'b1;
        smpl_in    = '0;
        for (int j = 0; j < win; j++) begin
            @(posedge clk);
            #1;
            sequencing = (j + 1 < len) || (j + 1 == gl);
            smpl_in    = (j < len && j < NT) ? samp[j] : 16'h0000;
            @(negedge clk);
            if (valid)   begin vcnt++; vcyc = j; end
            if (seq_err) begin ecnt++; ecyc = j; end
        end
    endtask

    task automatic check_burst(input string tag, input logic ev, input logic [15:0] out,
                               input logic ee, input int exp_ecyc,
                               input int vcnt, input int vcyc, input int ecnt, input int ecyc);
        chk({tag, "_vcnt"}, vcnt, ev ? 1 : 0);
        if (ev) chk({tag, "_vcyc"}, vcyc, NT + 2);
        chk({tag, "_out"}, {16'd0, smpl_out}, {16'd0, out});
        chk({tag, "_ecnt"}, ecnt, ee ? 1 : 0);
        if (ee) chk({tag, "_ecyc"}, ecyc, exp_ecyc);
    endtask

    initial begin
        int vcnt, vcyc, ecnt, ecyc;
        int len, win;
        logic        ev, ee;
        logic [15:0] eout, hold;
        int          eec;

        tbl[0] = '{8, 12, 0, 16'h4000, 16'h4000, 16'h1000, 16'h1000, 1'b1, 16'h4000, 1'b0, 0};
        tbl[1] = '{8, 12, 0, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 1'b1, 16'h7FFF, 1'b0, 0};
        tbl[2] = '{8, 12, 0, 16'h7FFF, 16'h7FFF, 16'h8000, 16'h8000, 1'b1, 16'h8000, 1'b0, 0};
        tbl[3] = '{5,  6, 0, 16'h4000, 16'h4000, 16'h1000, 16'h1000, 1'b0, 16'h8000, 1'b1, 5};
        tbl[4] = '{8, 12, 0, 16'h4000, 16'h4000, 16'h1000, 16'h1000, 1'b1, 16'h4000, 1'b0, 0};
        tbl[5] = '{10, 11, 0, 16'h4000, 16'h4000, 16'h1000, 16'h1000, 1'b0, 16'h4000, 1'b1, 8};
        tbl[6] = '{8, 12, 0, 16'h0001, 16'h0000, 16'h4000, 16'h0000, 1'b1, TINY_OUT, 1'b0, 0};
        tbl[7] = '{8, 12, 9, 16'h4000, 16'h4000, 16'h1000, 16'h1000, 1'b1, 16'h4000, 1'b1, 9};

        rst_n      = 1'b0;
        sequencing = 1'b0;
        smpl_in    = '0;
        fill(16'h0, 16'h0, 16'h0, 16'h0);
        #3;
        chk("init_smpl_out", {16'd0, smpl_out}, 32'h0);
        chk("init_valid", {31'd0, valid}, 32'h0);
        chk("init_seq_err", {31'd0, seq_err}, 32'h0);
        chk("init_coeff_addr", {21'd0, coeff_addr}, 32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed vectors.
        for (int i = 0; i < 8; i++) begin
            fill(tbl[i].c0, tbl[i].cr, tbl[i].s0, tbl[i].sr);
            run_burst(tbl[i].len, tbl[i].win, tbl[i].gl, vcnt, vcyc, ecnt, ecyc);
            check_burst($sformatf("vec%0d", i), tbl[i].ev, tbl[i].out, tbl[i].ee,
                        tbl[i].ecyc, vcnt, vcyc, ecnt, ecyc);
        end

        // Reset asserted at tap 4 of a burst.
        fill(16'h4000, 16'h4000, 16'h1000, 16'h1000);
        sequencing = 1'b1;
        smpl_in    = '0;
        for (int j = 0; j < 4; j++) begin
            @(posedge clk);
            #1;
            sequencing = 1'b1;
            smpl_in    = samp[j];
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_smpl_out", {16'd0, smpl_out}, 32'h0);
        chk("rst_valid", {31'd0, valid}, 32'h0);
        chk("rst_seq_err", {31'd0, seq_err}, 32'h0);
        chk("rst_coeff_addr", {21'd0, coeff_addr}, 32'h0);
        sequencing = 1'b0;
        smpl_in    = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        vcnt = 0; ecnt = 0;
        for (int j = 0; j < 14; j++) begin
            @(negedge clk);
            if (valid) vcnt++;
            if (seq_err) ecnt++;
        end
        chk("post_rst_vcnt", vcnt, 0);
        chk("post_rst_ecnt", ecnt, 0);
        chk("post_rst_out", {16'd0, smpl_out}, 32'h0);
        run_burst(NT, NT + 4, 0, vcnt, vcyc, ecnt, ecyc);
        check_burst("after_rst", 1'b1, 16'h4000, 1'b0, 0, vcnt, vcyc, ecnt, ecyc);

        // Randomized bursts of random length.
        hold = 16'h4000;
        for (int r = 0; r < 30; r++) begin
            int sh;
            sh = int'($urandom_range(0, 3));
            for (int k = 0; k < NT; k++) begin
                rom[k]  = 16'($urandom);
                samp[k] = 16'($urandom);
                if (sh != 0) samp[k] = 16'($signed(samp[k]) >>> (4 * sh));
            end
            len = int'($urandom_range(1, NT + 3));
            if (r % 3 == 0) len = NT;
            if (len == NT) begin
                ev = 1'b1; ee = 1'b0; eec = 0; eout = ref_out(); hold = eout; win = NT + 4;
            end else begin
                ev = 1'b0; ee = 1'b1; eout = hold; win = len + 1;
                eec = (len < NT) ? len : NT;
            end
            run_burst(len, win, 0, vcnt, vcyc, ecnt, ecyc);
            check_burst($sformatf("rnd%0d_len%0d", r, len), ev, eout, ee, eec,
                        vcnt, vcyc, ecnt, ecyc);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
